// File: rtl/tone_scheduler_if.sv
// Request/tone bundle between sound requesters and the tone scheduler.
interface tone_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DUR_W   = 10
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     req_freq;
  logic [DUR_W*NUM_REQ-1:0] req_dur;
  logic                     abort;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [1:0]               freq;
  logic                     en;
  logic                     busy;

  modport master (
    output req, req_freq, req_dur, abort,
    input  grant, done, freq, en, busy
  );

  modport slave (
    input  req, req_freq, req_dur, abort,
    output grant, done, freq, en, busy
  );
endinterface

// File: rtl/tone_scheduler.sv
// Round-robin sharing of one sine tone generator between sound requesters.
module tone_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TICK_CYCLES = 100_000,
  parameter int DUR_W       = 10,
  parameter int GAP_TICKS   = 20
) (
  input  logic            clk,
  input  logic            rst,
  tone_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam bit HAS_GAP = (GAP_TICKS > 0);
  localparam logic [PW-1:0] PRE_LD  = PW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LD  = GW'(GAP_TICKS);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [1:0]         freq_q, freq_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;

  logic [IW-1:0]      pick;
  logic [IW-1:0]      cand;
  logic               pick_ok;
  logic [DUR_W-1:0]   pick_dur;
  logic [1:0]         pick_freq;
  logic               tick;

  assign tick = (pre_q == '0);

  // first pending request after the last winner, wrapping around
  always_comb begin
    pick    = ptr_q;
    cand    = ptr_q;
    pick_ok = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!pick_ok && bus.req[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  assign pick_dur  = bus.req_dur[int'(pick)*DUR_W +: DUR_W];
  assign pick_freq = bus.req_freq[int'(pick)*2 +: 2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    grant_d = '0;
    done_d  = '0;
    freq_d  = freq_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          ptr_d         = pick;
          win_d         = pick;
          rem_d         = pick_dur;
          freq_d        = pick_freq;
          en_d          = |pick_dur;
          pre_d         = PRE_LD;
          grant_d[pick] = 1'b1;
          state_d       = PLAY;
        end
      end
      PLAY: begin
        pre_d = tick ? PRE_LD : pre_q - 1'b1;
        if (bus.abort || rem_q == '0 ||
            (tick && rem_q == DUR_W'(1))) begin
          en_d          = 1'b0;
          rem_d         = '0;
          done_d[win_q] = 1'b1;
          // a zero-length tone skips the gap unless it was aborted
          if (HAS_GAP && (bus.abort || rem_q != '0)) begin
            state_d = GAP;
            gap_d   = GAP_LD;
            pre_d   = PRE_LD;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          rem_d = rem_q - 1'b1;
        end
      end
      GAP: begin
        pre_d = tick ? PRE_LD : pre_q - 1'b1;
        if (tick) begin
          if (gap_q <= GW'(1)) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      win_q   <= '0;
      pre_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      freq_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.freq  = freq_q;
  assign bus.en    = en_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenarios plus random traffic
// checked every cycle against a timeline model of the tone schedule.
module tb_tone_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TICK    = 10;
  localparam int DUR_W   = 10;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tone_scheduler_if #(.NUM_REQ(NUM_REQ), .DUR_W(DUR_W)) bus ();

  tone_scheduler #(
    .NUM_REQ(NUM_REQ),
    .TICK_CYCLES(TICK),
    .DUR_W(DUR_W),
    .GAP_TICKS(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // model: absolute cycle stamps of grant, tone end and return to idle
  int         m_free, m_gnt, m_end, m_who, m_ptr, m_dur;
  logic [1:0] m_code;
  logic [31:0] e_grant, e_done, e_en, e_busy, e_freq;

  // observations for directed scenarios
  logic [NUM_REQ-1:0] g_q[$];
  int                 g_cyc[$];
  int                 en_cnt, done_cyc, fall_cyc;
  logic [NUM_REQ-1:0] done_val;
  logic [1:0]         en_freq;
  logic               prev_busy;

  task automatic model_reset();
    cyc       = 0;
    m_free    = 0;
    m_gnt     = -1;
    m_end     = -1;
    m_who     = 0;
    m_ptr     = NUM_REQ - 1;
    m_dur     = 0;
    m_code    = 2'd0;
    prev_busy = 1'b0;
  endtask

  task automatic clear_stats();
    g_q.delete();
    g_cyc.delete();
    en_cnt   = 0;
    done_cyc = -1;
    fall_cyc = -1;
    done_val = '0;
    en_freq  = 2'd0;
  endtask

  task automatic model_step();
    int  n;
    bit  found;
    n = cyc;
    if (n > m_free) begin
      if (bus.req != '0) begin
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
          int c;
          c = (m_ptr + i) % NUM_REQ;
          if (!found && bus.req[c]) begin
            found = 1'b1;
            m_who = c;
          end
        end
        m_ptr  = m_who;
        m_gnt  = n;
        m_code = bus.req_freq[2*m_who +: 2];
        m_dur  = int'(bus.req_dur[DUR_W*m_who +: DUR_W]);
        if (m_dur == 0) begin
          m_end  = n + 1;
          m_free = n + 1;
        end else begin
          m_end  = n + m_dur * TICK;
          m_free = m_end + GAP * TICK;
        end
      end
    end else if (bus.abort && n > m_gnt && n <= m_end) begin
      m_end  = n;
      m_free = n + GAP * TICK;
    end
    e_grant = (n == m_gnt) ? (32'd1 << m_who) : 32'd0;
    e_done  = (n == m_end) ? (32'd1 << m_who) : 32'd0;
    e_en    = 32'(m_dur > 0 && n >= m_gnt && n < m_end);
    e_busy  = 32'(n < m_free);
    e_freq  = 32'(m_code);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cyc++;
      model_step();
      check("grant", 32'(bus.grant), e_grant);
      check("done", 32'(bus.done), e_done);
      check("en", 32'(bus.en), e_en);
      check("busy", 32'(bus.busy), e_busy);
      check("freq", 32'(bus.freq), e_freq);
      if (bus.grant != '0) begin
        g_q.push_back(bus.grant);
        g_cyc.push_back(cyc);
      end
      if (bus.done != '0) begin
        done_cyc = cyc;
        done_val = bus.done;
      end
      if (bus.en) begin
        en_cnt++;
        en_freq = bus.freq;
      end
      if (prev_busy && !bus.busy) fall_cyc = cyc;
      prev_busy = bus.busy;
    end
  end

  task automatic wait_grant(string tag);
    int k;
    k = 0;
    while (g_q.size() == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_gnt_seen"}, 32'(g_q.size() > 0), 32'd1);
  endtask

  task automatic wait_idle(string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [NUM_REQ-1:0] exp_order [5];
  int k;

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req      = '0;
    bus.req_freq = '0;
    bus.req_dur  = '0;
    bus.abort    = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_en", 32'(bus.en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_freq", 32'(bus.freq), 32'd0);
    rst = 1'b0;

    // rotation with every requester held high
    @(negedge clk);
    clear_stats();
    bus.req_dur  = {10'd1, 10'd1, 10'd1, 10'd1};
    bus.req_freq = 8'b11_10_01_00;
    bus.req      = 4'b1111;
    k = 0;
    while (g_q.size() < 5 && k < 300) begin
      @(negedge clk);
      k++;
    end
    bus.req = '0;
    wait_idle("t2");
    for (int i = 0; i < 5; i++)
      check("t2_order", 32'(g_q[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4; i++)
      check("t2_space", 32'(g_cyc[i+1] - g_cyc[i]), 32'd31);

    // single tone with gap
    clear_stats();
    bus.req_freq = 8'(3 << 4);
    bus.req_dur  = 40'(5) << 20;
    bus.req      = 4'b0100;
    wait_grant("t1");
    bus.req = '0;
    wait_idle("t1");
    check("t1_grant", 32'(g_q[0]), 32'b0100);
    check("t1_en_len", 32'(en_cnt), 32'd50);
    check("t1_done_at", 32'(done_cyc - g_cyc[0]), 32'd50);
    check("t1_done_val", 32'(done_val), 32'b0100);
    check("t1_gap", 32'(fall_cyc - done_cyc), 32'd20);

    // zero-length tone
    clear_stats();
    bus.req_dur = '0;
    bus.req     = 4'b0010;
    wait_grant("t3");
    bus.req = '0;
    wait_idle("t3");
    check("t3_grant", 32'(g_q[0]), 32'b0010);
    check("t3_en_len", 32'(en_cnt), 32'd0);
    check("t3_done_at", 32'(done_cyc - g_cyc[0]), 32'd1);
    check("t3_done_val", 32'(done_val), 32'b0010);
    check("t3_nogap", 32'(fall_cyc - g_cyc[0]), 32'd1);

    // abort part way through a tone
    clear_stats();
    bus.req_dur = 40'(4);
    bus.req     = 4'b0001;
    wait_grant("t4");
    bus.req = '0;
    repeat (6) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_idle("t4");
    check("t4_en_len", 32'(en_cnt), 32'd7);
    check("t4_done_at", 32'(done_cyc - g_cyc[0]), 32'd7);
    check("t4_done_val", 32'(done_val), 32'b0001);
    check("t4_gap", 32'(fall_cyc - done_cyc), 32'd20);

    // request fields changed mid-tone have no effect
    clear_stats();
    bus.req_freq = 8'h80;
    bus.req_dur  = 40'(3) << 30;
    bus.req      = 4'b1000;
    wait_grant("t6");
    bus.req_freq = 8'h40;
    bus.req_dur  = 40'(9) << 30;
    bus.req      = '0;
    wait_idle("t6");
    check("t6_en_len", 32'(en_cnt), 32'd30);
    check("t6_freq", 32'(en_freq), 32'd2);

    // asynchronous reset in the middle of a tone
    clear_stats();
    bus.req_dur = 40'(8) << 10;
    bus.req     = 4'b0010;
    wait_grant("t5");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_en", 32'(bus.en), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_grant", 32'(bus.grant), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    clear_stats();
    bus.req_dur = {10'd2, 10'd2, 10'd2, 10'd2};
    bus.req     = 4'b1111;
    rst         = 1'b0;
    wait_grant("t5r");
    check("t5_first", 32'(g_q[0]), 32'b0001);
    bus.req = '0;
    wait_idle("t5r");

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        bus.req = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.req_freq[2*i +: 2]         = 2'($urandom_range(0, 3));
          bus.req_dur[DUR_W*i +: DUR_W]  = DUR_W'($urandom_range(0, 6));
        end
      end
      bus.abort = ($urandom_range(0, 39) == 0);
    end
    bus.req   = '0;
    bus.abort = 1'b0;
    wait_idle("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
